// File: rtl/instr_encoder_loader_pkg.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader_pkg
// Shared definitions for the MIPS program loader and the main control decoder:
//   - opcode field values for every instruction class the core understands
//   - in_kind encodings used on the loader's field-bundle stream
//   - loader FSM state codes
// ---------------------------------------------------------------------------
package instr_encoder_loader_pkg;

    // Primary opcode field (instr[31:26]); the main decoder keys off these too.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // Instruction class carried on in_kind.
    localparam logic [2:0] KIND_RTYPE   = 3'd0;
    localparam logic [2:0] KIND_LW      = 3'd1;
    localparam logic [2:0] KIND_SW      = 3'd2;
    localparam logic [2:0] KIND_BEQ     = 3'd3;
    localparam logic [2:0] KIND_ADDI    = 3'd4;
    localparam logic [2:0] KIND_J       = 3'd5;
    localparam logic [2:0] KIND_JAL     = 3'd6;
    localparam logic [2:0] KIND_ILLEGAL = 3'd7;

    // Loader session states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_FULL
    } state_e;

endpackage

// File: rtl/instr_encoder_loader_word_pack.sv
// ---------------------------------------------------------------------------
// instr_word_pack
// Purely combinational packer: turns one instruction field bundle into a
// 32-bit MIPS word. Fields that the selected format does not use are ignored.
// Ports:
//   kind     in  3   instruction class (KIND_*)
//   rs,rt,rd in  5   register fields
//   shamt    in  5   shift amount (R-type)
//   funct    in  6   function code (R-type)
//   imm      in  16  immediate / offset (I-type)
//   target   in  26  jump target (J-type)
//   word     out 32  packed instruction (0 when illegal)
//   illegal  out 1   kind has no encoding
// ---------------------------------------------------------------------------
module instr_word_pack
    import instr_encoder_loader_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            KIND_LW:    word = {OP_LW,   rs, rt, imm};
            KIND_SW:    word = {OP_SW,   rs, rt, imm};
            KIND_BEQ:   word = {OP_BEQ,  rs, rt, imm};
            KIND_ADDI:  word = {OP_ADDI, rs, rt, imm};
            KIND_J:     word = {OP_J,    target};
            KIND_JAL:   word = {OP_JAL,  target};
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
// Accepts instruction field bundles over a valid/ready stream, packs each into
// a MIPS word and writes it sequentially into the instruction-memory write
// port, one cycle after acceptance.
// Parameters:
//   ADDR_W     imem word-address width
//   BASE_ADDR  first word address written after start
// Ports:
//   clk, rst_n          clock / synchronous active-low reset
//   start               begin or restart a load session
//   in_valid, in_ready  bundle handshake
//   in_kind..in_target  instruction fields
//   in_last             bundle is the final instruction of the program
//   imem_we/addr/wdata  imem write port (registered)
//   count               words written this session
//   full                top of memory reached
//   done                last word committed (or illegal last bundle consumed)
//   err                 sticky illegal-kind flag for this session
// ---------------------------------------------------------------------------
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err
);

    // The pointer never wraps, so a session holds the words from BASE_ADDR up
    // to the top of memory.
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    state_e            state;
    logic              pend_last;
    logic [31:0]       packed_word;
    logic              illegal;
    logic              accept;
    logic              full_next;
    logic [ADDR_W:0]   in_flight;
    logic [ADDR_W:0]   count_inc;

    instr_word_pack u_pack (
        .kind    (in_kind),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .funct   (in_funct),
        .imm     (in_imm),
        .target  (in_target),
        .word    (packed_word),
        .illegal (illegal)
    );

    // Words committed plus the one in the write register; once this reaches
    // the limit nothing more may be accepted. Nothing is accepted behind a
    // pending last word either.
    assign in_flight = count + (ADDR_W+1)'(imem_we);
    assign full_next = (in_flight >= LIMIT);
    assign count_inc = count + (ADDR_W+1)'(1);
    assign in_ready  = (state == ST_LOAD) & ~start & ~full_next & ~pend_last;
    assign accept    = in_valid & in_ready;

    // A write presented in a start cycle still commits at its old address,
    // since imem_we/imem_addr are already registered; start only resets the
    // bookkeeping at the end of that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pend_last  <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= '0;
            count      <= '0;
            full       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (accept && !illegal) begin
                imem_we    <= 1'b1;
                imem_wdata <= packed_word;
            end

            if (start) begin
                state     <= ST_LOAD;
                pend_last <= 1'b0;
                imem_addr <= BASE;
                count     <= '0;
                full      <= 1'b0;
                done      <= 1'b0;
                err       <= 1'b0;
            end else begin
                if (imem_we) begin
                    count <= count_inc;
                    if (count_inc < LIMIT) begin
                        imem_addr <= imem_addr + ADDR_W'(1);
                    end else begin
                        full <= 1'b1;
                        if (!pend_last) state <= ST_FULL;
                    end
                    if (pend_last) begin
                        pend_last <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                if (accept) begin
                    if (illegal) begin
                        err <= 1'b1;
                        if (in_last) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else begin
                        pend_last <= in_last;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder_loader
// Self-checking bench: a 64-word loader (default parameters) and a 4-word
// loader (ADDR_W=2) sharing clock, reset and instruction fields.
// ---------------------------------------------------------------------------
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, in_valid, in_last;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        in_ready, imem_we, full, done, err;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  count;

    logic        s_start, s_valid;
    logic        s_ready, s_we, s_full, s_done, s_err;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    int checks = 0;
    int errors = 0;

    int          got_a[$];
    logic [31:0] got_d[$];
    int          exp_a[$];
    logic [31:0] exp_d[$];
    int          sgot_a[$];
    logic [31:0] sgot_d[$];

    always #5 clk = ~clk;

    instr_encoder_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
        .full(full), .done(done), .err(err)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata), .count(s_count),
        .full(s_full), .done(s_done), .err(s_err)
    );

    // Write monitors: imem_we lasts one cycle, so one negedge sees each write.
    always @(negedge clk) begin
        if (imem_we) begin
            got_a.push_back(int'(imem_addr));
            got_d.push_back(imem_wdata);
        end
        if (s_we) begin
            sgot_a.push_back(int'(s_addr));
            sgot_d.push_back(s_wdata);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic        last;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[8];

    // Reference encoder built from field positions with plain arithmetic.
    function automatic logic [31:0] refEncode(input int kind, input longint rs, input longint rt,
                                              input longint rd, input longint shamt, input longint funct,
                                              input longint imm, input longint target);
        longint op = 0;
        longint w;
        case (kind)
            1: op = 35;
            2: op = 43;
            3: op = 4;
            4: op = 8;
            5: op = 2;
            6: op = 3;
            default: op = 0;
        endcase
        if (kind == 0)
            w = rs * 2097152 + rt * 65536 + rd * 2048 + shamt * 64 + funct;
        else if (kind <= 4)
            w = op * 67108864 + rs * 2097152 + rt * 65536 + imm;
        else
            w = op * 67108864 + target;
        return 32'(w);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                                 input logic [15:0] imm, input logic [25:0] target, input logic last);
        in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = shamt;
        in_funct = funct; in_imm = imm; in_target = target; in_last = last;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clearQueues();
        got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic compareWrites(input string tag);
        checkOutput({tag, "_nwrites"}, 32'(got_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            checkOutput({tag, "_addr"}, 32'(got_a[i]), 32'(exp_a[i]));
            checkOutput({tag, "_data"}, got_d[i], exp_d[i]);
        end
    endtask

    task automatic randomSession();
        int n;
        int nw = 0;
        logic exp_err = 1'b0;
        n = $urandom_range(1, 20);
        clearQueues();
        pulseStart();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            applyStimulus(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
                          5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom), i == n - 1);
            in_valid = 1'b1;
            #1;
            checkOutput("rnd_ready", 32'(in_ready), 32'd1);
            if (in_kind == 3'd7) begin
                exp_err = 1'b1;
            end else begin
                exp_a.push_back(nw);
                exp_d.push_back(refEncode(int'(in_kind), longint'(in_rs), longint'(in_rt), longint'(in_rd),
                                          longint'(in_shamt), longint'(in_funct), longint'(in_imm),
                                          longint'(in_target)));
                nw++;
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        checkOutput("rnd_done", 32'(done), 32'd1);
        checkOutput("rnd_err", 32'(err), 32'(exp_err));
        checkOutput("rnd_count", 32'(count), 32'(nw));
        checkOutput("rnd_ready_after", 32'(in_ready), 32'd0);
        compareWrites("rnd");
    endtask

    initial begin
        int accepted;
        int offered;

        vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0,    26'h0,       1'b0, 32'h00221820};
        vecs[1] = '{3'd1, 5'd29, 5'd8,  5'd0,  5'd0,  6'h0,  16'h0004, 26'h0,       1'b0, 32'h8FA80004};
        vecs[2] = '{3'd3, 5'd1,  5'd2,  5'd0,  5'd0,  6'h0,  16'hFFFF, 26'h0,       1'b0, 32'h1022FFFF};
        vecs[3] = '{3'd2, 5'd29, 5'd31, 5'd0,  5'd0,  6'h0,  16'h0008, 26'h0,       1'b0, 32'hAFBF0008};
        vecs[4] = '{3'd4, 5'd0,  5'd4,  5'd0,  5'd0,  6'h0,  16'h1234, 26'h0,       1'b0, 32'h20041234};
        vecs[5] = '{3'd6, 5'd0,  5'd0,  5'd0,  5'd0,  6'h0,  16'h0,    26'h3FFFFFF, 1'b0, 32'h0FFFFFFF};
        vecs[6] = '{3'd0, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0,    26'h0,       1'b0, 32'h03FFFFFF};
        vecs[7] = '{3'd5, 5'd0,  5'd0,  5'd0,  5'd0,  6'h0,  16'h0,    26'h10,      1'b1, 32'h08000010};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; s_start = 1'b0; s_valid = 1'b0;
        applyStimulus(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);

        // Reset held two cycles, then released without start.
        tick(); tick();
        checkOutput("rst_we", 32'(imem_we), 32'd0);
        checkOutput("rst_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst_wdata", imem_wdata, 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_flags", {29'd0, full, done, err}, 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_ready", 32'(in_ready), 32'd0);
        checkOutput("idle_small_ready", 32'(s_ready), 32'd0);

        // Table of known encodings, offered back-to-back; unused fields scrambled.
        clearQueues();
        pulseStart();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k].kind, vecs[k].rs, vecs[k].rt, vecs[k].rd, vecs[k].shamt,
                          vecs[k].funct, vecs[k].imm, vecs[k].target, vecs[k].last);
            if (vecs[k].kind == 3'd0) begin
                in_imm = 16'($urandom); in_target = 26'($urandom);
            end else if (vecs[k].kind <= 3'd4) begin
                in_rd = 5'($urandom); in_shamt = 5'($urandom); in_funct = 6'($urandom);
                in_target = 26'($urandom);
            end else begin
                in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
                in_shamt = 5'($urandom); in_funct = 6'($urandom); in_imm = 16'($urandom);
            end
            in_valid = 1'b1;
            #1;
            checkOutput("tbl_ready", 32'(in_ready), 32'd1);
            tick();
            checkOutput("tbl_we", 32'(imem_we), 32'd1);
            checkOutput("tbl_addr", 32'(imem_addr), 32'(k));
            checkOutput("tbl_data", imem_wdata, vecs[k].exp_word);
            checkOutput("tbl_count", 32'(count), 32'(k));
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        checkOutput("tbl_done", 32'(done), 32'd1);
        checkOutput("tbl_ready_done", 32'(in_ready), 32'd0);
        checkOutput("tbl_count_final", 32'(count), 32'd8);
        checkOutput("tbl_nwrites", 32'(got_a.size()), 32'd8);

        // Illegal kind: consumed without a write, sets err; next word still at 0.
        clearQueues();
        pulseStart();
        applyStimulus(3'd7, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1, 1'b0);
        in_valid = 1'b1;
        tick();
        checkOutput("ill_we", 32'(imem_we), 32'd0);
        checkOutput("ill_err", 32'(err), 32'd1);
        applyStimulus(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        checkOutput("ill_next_we", 32'(imem_we), 32'd1);
        checkOutput("ill_next_addr", 32'(imem_addr), 32'd0);
        tick();
        pulseStart();
        checkOutput("ill_start_clears_err", 32'(err), 32'd0);
        checkOutput("ill_start_clears_count", 32'(count), 32'd0);
        applyStimulus(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        checkOutput("ill_last_done", 32'(done), 32'd1);
        checkOutput("ill_last_err", 32'(err), 32'd1);
        checkOutput("ill_last_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("ill_last_nowrite", 32'(got_a.size()), 32'd1);

        // Start while a write is pending: it lands at its old address, then counters reset.
        pulseStart();
        clearQueues();
        applyStimulus(3'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_imm = 16'h0002;
        tick();
        checkOutput("rs_pending_we", 32'(imem_we), 32'd1);
        checkOutput("rs_pending_addr", 32'(imem_addr), 32'd1);
        in_imm = 16'h0003;
        start = 1'b1;
        #1;
        checkOutput("rs_no_accept", 32'(in_ready), 32'd0);
        tick();
        start = 1'b0; in_valid = 1'b0;
        checkOutput("rs_we_after", 32'(imem_we), 32'd0);
        checkOutput("rs_count_after", 32'(count), 32'd0);
        checkOutput("rs_addr_after", 32'(imem_addr), 32'd0);
        exp_a.push_back(0); exp_d.push_back(32'h20220001);
        exp_a.push_back(1); exp_d.push_back(32'h20220002);
        tick();
        compareWrites("rs");

        // Four-word loader offered five ADDI bundles: four writes, then full.
        sgot_a.delete(); sgot_d.delete();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        accepted = 0;
        offered  = 0;
        applyStimulus(3'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            in_imm  = 16'(offered);
            s_valid = (offered < 5);
            #1;
            if (s_valid && s_ready) begin
                accepted++;
                offered++;
            end
            tick();
        end
        checkOutput("sm_accepted", 32'(accepted), 32'd4);
        checkOutput("sm_full", 32'(s_full), 32'd1);
        checkOutput("sm_ready_held", 32'(s_ready), 32'd0);
        checkOutput("sm_count", 32'(s_count), 32'd4);
        checkOutput("sm_addr_top", 32'(s_addr), 32'd3);
        checkOutput("sm_nwrites", 32'(sgot_a.size()), 32'd4);
        for (int i = 0; i < sgot_a.size() && i < 4; i++) begin
            checkOutput("sm_waddr", 32'(sgot_a[i]), 32'(i));
            checkOutput("sm_wdata", sgot_d[i], refEncode(4, 1, 2, 0, 0, 0, longint'(i), 0));
        end
        s_valid = 1'b0;

        // Randomized sessions against the reference encoder.
        for (int s = 0; s < 12; s++) randomSession();

        // Reset in the accept cycle aborts the pending write.
        pulseStart();
        clearQueues();
        applyStimulus(3'd1, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00AA, 26'd0, 1'b0);
        in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        tick();
        in_valid = 1'b0;
        checkOutput("mr_we", 32'(imem_we), 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        checkOutput("mr_nowrites", 32'(got_a.size()), 32'd0);
        checkOutput("mr_ready", 32'(in_ready), 32'd0);
        checkOutput("mr_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
